mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: ports A and B share one combinational-read memory.
// Each access takes one GRANT cycle; ties alternate between the two ports.
module mem_arbiter #(
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req_in,
  input  logic [31:0] a_addr_in,
  input  logic [31:0] a_data_in,
  input  logic [1:0]  a_size_in,
  input  logic        a_we_in,
  output logic        a_ack_out,
  output logic        a_err_out,
  output logic [31:0] a_data_out,
  input  logic        b_req_in,
  input  logic [31:0] b_addr_in,
  input  logic [31:0] b_data_in,
  input  logic [1:0]  b_size_in,
  input  logic        b_we_in,
  output logic        b_ack_out,
  output logic        b_err_out,
  output logic [31:0] b_data_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [1:0]  mem_size_out,
  output logic        mem_we_out,
  output logic        mem_re_out,
  input  logic [31:0] mem_data_in,
  output logic [1:0]  state_dbg_out
);

  // Handshake: a port holds req until its one-cycle ack; while ack is high the
  // same port's req is ignored, so a fresh request is seen from the next cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_data_q, lat_data_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_we_q, lat_we_d;
  logic        a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic        b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [31:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic        a_elig, b_elig, err, in_grant;

  assign a_elig = a_req_in & ~a_ack_q;
  assign b_elig = b_req_in & ~b_ack_q;

  assign err = (lat_addr_q[31:16] != MEM_ADDR)
            || ((lat_size_q == 2'd3) && (lat_addr_q[1:0] != 2'b00))
            || ((lat_size_q == 2'd1) && lat_addr_q[0])
            || (lat_size_q == 2'd2);

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_size_d = lat_size_q;
    lat_we_d   = lat_we_q;
    a_ack_d    = 1'b0;
    a_err_d    = 1'b0;
    a_data_d   = a_data_q;
    b_ack_d    = 1'b0;
    b_err_d    = 1'b0;
    b_data_d   = b_data_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that was not granted last wins.
        if (a_elig && (!b_elig || last_b_q)) begin
          state_d    = GRANT_A;
          last_b_d   = 1'b0;
          lat_addr_d = a_addr_in;
          lat_data_d = a_data_in;
          lat_size_d = a_size_in;
          lat_we_d   = a_we_in;
        end else if (b_elig) begin
          state_d    = GRANT_B;
          last_b_d   = 1'b1;
          lat_addr_d = b_addr_in;
          lat_data_d = b_data_in;
          lat_size_d = b_size_in;
          lat_we_d   = b_we_in;
        end
      end
      GRANT_A: begin
        state_d  = IDLE;
        a_ack_d  = 1'b1;
        a_err_d  = err;
        a_data_d = err ? 32'h0 : mem_data_in;
      end
      GRANT_B: begin
        state_d  = IDLE;
        b_ack_d  = 1'b1;
        b_err_d  = err;
        b_data_d = err ? 32'h0 : mem_data_in;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      lat_addr_q <= 32'h0;
      lat_data_q <= 32'h0;
      lat_size_q <= 2'd0;
      lat_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      a_data_q   <= 32'h0;
      b_ack_q    <= 1'b0;
      b_err_q    <= 1'b0;
      b_data_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_size_q <= lat_size_d;
      lat_we_q   <= lat_we_d;
      a_ack_q    <= a_ack_d;
      a_err_q    <= a_err_d;
      a_data_q   <= a_data_d;
      b_ack_q    <= b_ack_d;
      b_err_q    <= b_err_d;
      b_data_q   <= b_data_d;
    end
  end

  assign in_grant     = (state_q == GRANT_A) || (state_q == GRANT_B);
  assign mem_addr_out = in_grant ? lat_addr_q : 32'h0;
  assign mem_data_out = in_grant ? lat_data_q : 32'h0;
  assign mem_size_out = in_grant ? lat_size_q : 2'd0;
  // Reset gates the strobes so an aborted grant never commits at the reset edge.
  assign mem_we_out   = in_grant & lat_we_q & ~err & ~reset;
  assign mem_re_out   = in_grant & ~lat_we_q & ~err & ~reset;

  assign a_ack_out     = a_ack_q;
  assign a_err_out     = a_err_q;
  assign a_data_out    = a_data_q;
  assign b_ack_out     = b_ack_q;
  assign b_err_out     = b_err_q;
  assign b_data_out    = b_data_q;
  assign state_dbg_out = state_q;

endmodule
